// File: rtl/seq_fsm_ctrl_pkg.sv
// Shared encodings for the {r,x,d,b} recognizer and its controller.
package seq_fsm_ctrl_pkg;

  // Legal state encodings {r,x,d,b}
  localparam logic [3:0] S_L  = 4'b0000;
  localparam logic [3:0] S_B_ = 4'b0001;
  localparam logic [3:0] S_D_ = 4'b0010;
  localparam logic [3:0] S_A  = 4'b0100;
  localparam logic [3:0] S_B  = 4'b0101;
  localparam logic [3:0] S_D  = 4'b0110;
  localparam logic [3:0] S_BD = 4'b0111;
  localparam logic [3:0] S_BA = 4'b1101;
  localparam logic [3:0] S_DA = 4'b1110;
  localparam logic [3:0] S_X  = 4'b1111;

  // Input symbols {i1,i0}; SYM_11 is the reset symbol
  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_10 = 2'b10;
  localparam logic [1:0] SYM_11 = 2'b11;

  // True for the ten encodings the recognizer can legitimately hold
  function automatic logic is_legal(logic [3:0] s);
    case (s)
      S_L, S_B_, S_D_, S_A, S_B, S_D, S_BD, S_BA, S_DA, S_X: is_legal = 1'b1;
      default:                                              is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_fsm_next.sv
// Combinational next-state function of the recognizer; no storage here.
module seq_fsm_next
  import seq_fsm_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [1:0] sym_i,
  output logic [3:0] next_o,
  output logic       legal_o
);

  // Table lookup: symbol 11 always returns to S_L, illegal states map to S_L
  always_comb begin
    next_o  = S_L;
    legal_o = is_legal(state_i);
    if (sym_i != SYM_11) begin
      case (state_i)
        S_L:  next_o = (sym_i == SYM_00) ? S_A  : (sym_i == SYM_01) ? S_B_ : S_D_;
        S_B_: next_o = (sym_i == SYM_00) ? S_A  : (sym_i == SYM_01) ? S_B_ : S_D;
        S_D_: next_o = (sym_i == SYM_00) ? S_A  : (sym_i == SYM_01) ? S_B  : S_D_;
        S_A:  next_o = (sym_i == SYM_00) ? S_A  : (sym_i == SYM_01) ? S_B  : S_D;
        S_B:  next_o = (sym_i == SYM_00) ? S_BA : (sym_i == SYM_01) ? S_B  : S_BD;
        S_D:  next_o = (sym_i == SYM_00) ? S_DA : (sym_i == SYM_01) ? S_BD : S_D;
        S_BD: next_o = (sym_i == SYM_00) ? S_BD : S_X;
        S_BA: next_o = (sym_i == SYM_00) ? S_BA : (sym_i == SYM_01) ? S_X  : S_BD;
        S_DA: next_o = (sym_i == SYM_00) ? S_DA : (sym_i == SYM_01) ? S_BD : S_X;
        S_X:  next_o = S_X;
        default: next_o = S_L;
      endcase
    end
  end

endmodule

// File: rtl/seq_fsm_ctrl.sv
// Registered recognizer controller: paced symbol intake, accept pulse and
// saturating count, inactivity timeout and illegal-state recovery.
//
// Handshake: sym_valid may be raised at any time; a symbol is consumed on a
// clk edge where sym_valid & sym_ready are both high. sym_ready depends
// combinationally on clr and on the legality of the held state.
module seq_fsm_ctrl
  import seq_fsm_ctrl_pkg::*;
#(
  parameter int unsigned STEP_GAP = 2,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sym_valid,
  input  logic [1:0]       sym,
  output logic             sym_ready,
  output logic [3:0]       state,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             tmo,
  output logic             err
);

  localparam int unsigned GAP_W  = (STEP_GAP > 1) ? $clog2(STEP_GAP + 1) : 1;
  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(STEP_GAP);
  // Timeout fires on the edge that completes the TIMEOUT-th idle cycle
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [3:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic              tmo_q, tmo_d;
  logic              err_q, err_d;

  logic [3:0] next_state;
  logic       legal;
  logic       xfer;

  seq_fsm_next u_next (
    .state_i (state_q),
    .sym_i   (sym),
    .next_o  (next_state),
    .legal_o (legal)
  );

  assign xfer = sym_valid & sym_ready;

  // State register and all counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_L;
      ready_q   <= 1'b1;
      gap_q     <= '0;
      idle_q    <= '0;
      hit_q     <= 1'b0;
      hit_cnt_q <= '0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      gap_q     <= gap_d;
      idle_q    <= idle_d;
      hit_q     <= hit_d;
      hit_cnt_q <= hit_cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  // Next state with edge priority clr > illegal > transfer > timeout > hold
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    gap_d     = gap_q;
    idle_d    = idle_q;
    hit_d     = 1'b0;
    hit_cnt_d = hit_cnt_q;
    tmo_d     = 1'b0;
    err_d     = err_q;

    // Pacing gap counts down independently of the state path
    if (!ready_q) begin
      if (gap_q <= GAP_W'(1)) begin
        ready_d = 1'b1;
        gap_d   = '0;
      end else begin
        gap_d = gap_q - GAP_W'(1);
      end
    end

    if (clr) begin
      state_d   = S_L;
      ready_d   = 1'b1;
      gap_d     = '0;
      idle_d    = '0;
      hit_cnt_d = '0;
      err_d     = 1'b0;
    end else if (!legal) begin
      state_d = S_L;
      err_d   = 1'b1;
      idle_d  = '0;
    end else if (xfer) begin
      state_d = next_state;
      idle_d  = '0;
      hit_d   = (next_state == S_X) && (state_q != S_X);
      if (hit_d && (hit_cnt_q != CNT_MAX)) hit_cnt_d = hit_cnt_q + 1'b1;
      if (STEP_GAP != 0) begin
        ready_d = 1'b0;
        gap_d   = GAP_LOAD;
      end
    end else if (state_q == S_L) begin
      idle_d = '0;
    end else if ((TIMEOUT != 0) && (idle_q == IDLE_LAST)) begin
      state_d = S_L;
      tmo_d   = 1'b1;
      idle_d  = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Outputs: registered flags plus the combinational ready
  always_comb begin
    sym_ready = ready_q & ~clr & legal;
    state     = state_q;
    hit       = hit_q;
    hit_cnt   = hit_cnt_q;
    tmo       = tmo_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_seq_fsm_ctrl.sv
// Bench for seq_fsm_ctrl: two instances (unpaced/short timeout/2-bit count and
// paced/long timeout/8-bit count) share inputs and are both tracked by a
// table-driven behavioural model.
module tb_seq_fsm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, clr, sym_valid;
  logic [1:0] sym;

  logic       a_ready, a_hit, a_tmo, a_err;
  logic [3:0] a_state;
  logic [1:0] a_cnt;
  logic       b_ready, b_hit, b_tmo, b_err;
  logic [3:0] b_state;
  logic [7:0] b_cnt;

  int checks   = 0;
  int failures = 0;

  // Clock
  always #5 clk = ~clk;

  seq_fsm_ctrl #(.STEP_GAP(0), .TIMEOUT(5), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sym_valid(sym_valid), .sym(sym),
    .sym_ready(a_ready), .state(a_state), .hit(a_hit), .hit_cnt(a_cnt),
    .tmo(a_tmo), .err(a_err)
  );

  seq_fsm_ctrl #(.STEP_GAP(2), .TIMEOUT(1000), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sym_valid(sym_valid), .sym(sym),
    .sym_ready(b_ready), .state(b_state), .hit(b_hit), .hit_cnt(b_cnt),
    .tmo(b_tmo), .err(b_err)
  );

  // Reference model: per-instance parameters and abstract state
  int gap_p[2] = '{0, 2};
  int lim_p[2] = '{5, 1000};
  int max_p[2] = '{3, 255};
  logic [3:0] tbl [16][3];
  bit         lgl [16];
  int m_state[2], m_wait[2], m_idle[2], m_hit[2], m_cnt[2], m_tmo[2], m_err[2];

  function automatic int exp_ready(int k);
    return (m_wait[k] == 0 && !clr && lgl[m_state[k]]) ? 1 : 0;
  endfunction

  task automatic chk(string tag, logic [7:0] got, int exp);
    checks++;
    assert (got === 8'(exp)) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_wait[k] = 0; m_idle[k] = 0;
      m_hit[k] = 0; m_cnt[k] = 0; m_tmo[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(int k, bit xf);
    int nx;
    m_hit[k] = 0;
    m_tmo[k] = 0;
    if (clr) begin
      m_state[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_wait[k] = 0; m_idle[k] = 0;
    end else if (!lgl[m_state[k]]) begin
      m_state[k] = 0; m_err[k] = 1; m_idle[k] = 0;
      if (m_wait[k] > 0) m_wait[k]--;
    end else if (xf) begin
      nx = (sym == 2'b11) ? 0 : int'(tbl[m_state[k]][sym]);
      if (nx == 15 && m_state[k] != 15) begin
        m_hit[k] = 1;
        if (m_cnt[k] < max_p[k]) m_cnt[k]++;
      end
      m_state[k] = nx; m_wait[k] = gap_p[k]; m_idle[k] = 0;
    end else begin
      if (m_wait[k] > 0) m_wait[k]--;
      if (m_state[k] == 0) m_idle[k] = 0;
      else begin
        m_idle[k]++;
        if (m_idle[k] == lim_p[k]) begin
          m_state[k] = 0; m_tmo[k] = 1; m_idle[k] = 0;
        end
      end
    end
  endtask

  task automatic chk_outs();
    chk("a_state", 8'(a_state), m_state[0]);
    chk("a_hit", 8'(a_hit), m_hit[0]);
    chk("a_cnt", 8'(a_cnt), m_cnt[0]);
    chk("a_tmo", 8'(a_tmo), m_tmo[0]);
    chk("a_err", 8'(a_err), m_err[0]);
    chk("b_state", 8'(b_state), m_state[1]);
    chk("b_hit", 8'(b_hit), m_hit[1]);
    chk("b_cnt", b_cnt, m_cnt[1]);
    chk("b_tmo", 8'(b_tmo), m_tmo[1]);
    chk("b_err", 8'(b_err), m_err[1]);
  endtask

  // One clock: check ready before the edge, advance model, check after
  task automatic tick();
    bit xa, xb;
    #1;
    chk("a_ready", 8'(a_ready), exp_ready(0));
    chk("b_ready", 8'(b_ready), exp_ready(1));
    xa = sym_valid && (exp_ready(0) == 1);
    xb = sym_valid && (exp_ready(1) == 1);
    @(posedge clk);
    model_step(0, xa);
    model_step(1, xb);
    @(negedge clk);
    chk_outs();
  endtask

  task automatic drive(bit v, logic [1:0] s, bit c);
    sym_valid = v;
    sym       = s;
    clr       = c;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; sym_valid = 1'b0; sym = 2'b00;
    model_reset();
    @(negedge clk);
    chk("rst_a_ready", 8'(a_ready), 1);
    chk("rst_b_ready", 8'(b_ready), 1);
    chk_outs();
    rst_n = 1'b1;
  endtask

  task automatic accept_seq();
    drive(1, 2'b00, 0);
    drive(1, 2'b10, 0);
    drive(1, 2'b01, 0);
    drive(1, 2'b01, 0);
  endtask

  // Safety net against a hung run
  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed and random steps
  initial begin
    logic [6:0] pat;
    int idle_burst;

    for (int s = 0; s < 16; s++) begin
      lgl[s] = 1'b0;
      for (int j = 0; j < 3; j++) tbl[s][j] = 4'h0;
    end
    tbl[0]  = '{4'h4, 4'h1, 4'h2};
    tbl[1]  = '{4'h4, 4'h1, 4'h6};
    tbl[2]  = '{4'h4, 4'h5, 4'h2};
    tbl[4]  = '{4'h4, 4'h5, 4'h6};
    tbl[5]  = '{4'hD, 4'h5, 4'h7};
    tbl[6]  = '{4'hE, 4'h7, 4'h6};
    tbl[7]  = '{4'h7, 4'hF, 4'hF};
    tbl[13] = '{4'hD, 4'hF, 4'h7};
    tbl[14] = '{4'hE, 4'h7, 4'hF};
    tbl[15] = '{4'hF, 4'hF, 4'hF};
    lgl[0] = 1; lgl[1] = 1; lgl[2] = 1; lgl[4] = 1; lgl[5] = 1;
    lgl[6] = 1; lgl[7] = 1; lgl[13] = 1; lgl[14] = 1; lgl[15] = 1;

    // Reset values
    do_reset();
    chk("rst_state", 8'(a_state), 0);
    chk("rst_cnt", b_cnt, 0);

    // Accept path, back-to-back on the unpaced instance
    drive(1, 2'b00, 0); chk("acc_s1", 8'(a_state), 4'h4);
    drive(1, 2'b10, 0); chk("acc_s2", 8'(a_state), 4'h6);
    drive(1, 2'b01, 0); chk("acc_s3", 8'(a_state), 4'h7);
    drive(1, 2'b01, 0); chk("acc_s4", 8'(a_state), 4'hF);
    chk("acc_hit", 8'(a_hit), 1);
    chk("acc_cnt", 8'(a_cnt), 1);
    drive(1, 2'b00, 0);
    chk("acc_stay", 8'(a_state), 4'hF);
    chk("acc_nohit", 8'(a_hit), 0);

    // Reset symbol, re-entry and saturation of the 2-bit count
    drive(1, 2'b11, 0); chk("rsym_state", 8'(a_state), 0);
    accept_seq();
    chk("reent_cnt", 8'(a_cnt), 2);
    for (int r = 0; r < 3; r++) begin
      drive(1, 2'b11, 0);
      accept_seq();
    end
    chk("sat_cnt", 8'(a_cnt), 3);

    // Pacing on the STEP_GAP=2 instance
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sym_valid = 1'b1; sym = 2'b00; clr = 1'b0;
      #1 pat[6-i] = b_ready;
      tick();
    end
    chk("pace_pat", 8'(pat), 7'b1001001);
    chk("pace_state", 8'(b_state), 4'h4);

    // Timeout on the TIMEOUT=5 instance
    do_reset();
    drive(1, 2'b00, 0);
    for (int i = 0; i < 4; i++) drive(0, 2'b00, 0);
    chk("tmo_early", 8'(a_tmo), 0);
    chk("tmo_early_state", 8'(a_state), 4'h4);
    drive(0, 2'b00, 0);
    chk("tmo_pulse", 8'(a_tmo), 1);
    chk("tmo_state", 8'(a_state), 0);
    drive(1, 2'b00, 0);
    for (int i = 0; i < 4; i++) drive(0, 2'b00, 0);
    drive(1, 2'b01, 0);
    chk("tmo_pre_xfer", 8'(a_tmo), 0);
    chk("tmo_pre_state", 8'(a_state), 4'h5);

    // Illegal encoding recovery
    do_reset();
    force u_a.state_q = 4'hA;
    m_state[0] = 10;
    #1;
    release u_a.state_q;
    sym_valid = 1'b1; sym = 2'b00; clr = 1'b0;
    tick();
    chk("ill_state", 8'(a_state), 0);
    chk("ill_err", 8'(a_err), 1);
    drive(0, 2'b00, 0);
    chk("ill_sticky", 8'(a_err), 1);

    // Synchronous clear with a symbol offered
    accept_seq();
    chk("clr_pre_cnt", 8'(a_cnt), 1);
    drive(1, 2'b00, 1);
    chk("clr_err", 8'(a_err), 0);
    chk("clr_cnt", 8'(a_cnt), 0);
    chk("clr_state", 8'(a_state), 0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        idle_burst = $urandom_range(3, 7);
        for (int i = 0; i < idle_burst; i++) drive(0, 2'b00, 0);
      end
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
            $urandom_range(0, 99) == 0);
    end

    // Asynchronous reset in the middle of a pacing gap
    do_reset();
    drive(1, 2'b00, 0);
    drive(0, 2'b00, 0);
    drive(0, 2'b00, 0);
    drive(1, 2'b10, 0);
    drive(0, 2'b00, 0);
    drive(0, 2'b00, 0);
    drive(1, 2'b01, 0);
    sym_valid = 1'b0;
    chk("ar_pre_state", 8'(b_state), 4'h7);
    chk("ar_pre_ready", 8'(b_ready), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_state", 8'(b_state), 0);
    chk("ar_ready", 8'(b_ready), 1);
    chk("ar_cnt", b_cnt, 0);
    chk("ar_hit", 8'(b_hit), 0);
    chk("ar_a_state", 8'(a_state), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk_outs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
